// File: rtl/phase_timer_pkg.sv
// Shared types and helpers for the phase timer: channel state encoding,
// default timing constants and BCD conversion/decrement helpers.
package phase_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ch_state_t;

   localparam int DEF_TICK_DIV  = 50000000;
   localparam int DEF_LONG_SEC  = 25;
   localparam int DEF_SHORT_SEC = 5;

   // Two BCD nibbles {tens, ones} for a value in 1..99.
   function automatic logic [7:0] to_bcd(input int v);
      int t;
      int o;
      t = v / 10;
      o = v % 10;
      return {t[3:0], o[3:0]};
   endfunction

   // One-second BCD decrement, saturating at 00.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v == 8'h00)
         return 8'h00;
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

endpackage

// File: rtl/phase_timer_channel.sv
// One phase channel: state machine, BCD seconds down-counter and the
// registered completion pulse.
//
// state | meaning
// IDLE  | waiting for en; count held at 00
// RUN   | counting down one second per tick
// DONE  | expired, fin already pulsed; waits for en to drop
module timer_channel
   import phase_timer_pkg::*;
#(
   parameter int SEC = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       tick,
   input  logic       inhibit,
   output logic       fin,
   output logic       running,
   output logic       active,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   localparam logic [7:0] LOAD_BCD = to_bcd(SEC);

   ch_state_t  state;
   ch_state_t  state_nxt;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;
   logic       fin_nxt;
   logic       go;
   logic       last;

   // An inhibited channel behaves exactly as if its enable were low.
   assign go   = en & ~inhibit;
   assign last = (cnt == 8'h01);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 8'h00;
         fin   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         fin   <= fin_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (go) begin
               state_nxt = RUN;
               cnt_nxt   = LOAD_BCD;
            end
         end
         RUN: begin
            if (!go) begin
               state_nxt = IDLE;
               cnt_nxt   = 8'h00;
            end else if (tick) begin
               if (last) begin
                  state_nxt = DONE;
                  cnt_nxt   = 8'h00;
               end else begin
                  cnt_nxt = bcd_dec(cnt);
               end
            end
         end
         DONE: begin
            if (!go) begin
               state_nxt = IDLE;
               cnt_nxt   = 8'h00;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'h00;
         end
      endcase
   end

   always_comb begin
      fin_nxt = (state == RUN) && go && tick && last;
      running = (state == RUN);
      active  = (state == RUN) || (state == DONE);
      tens    = cnt[7:4];
      ones    = cnt[3:0];
   end

endmodule

// File: rtl/phase_timer.sv
// Phase timer top: shared one-second prescaler, long/short channels with
// long-phase priority, sticky conflict flag and the BCD display mux.
module phase_timer
   import phase_timer_pkg::*;
#(
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int LONG_SEC  = DEF_LONG_SEC,
   parameter int SHORT_SEC = DEF_SHORT_SEC,
   parameter int PW        = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en25,
   input  logic       en5,
   output logic       fin25,
   output logic       fin5,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       busy,
   output logic       err
);

   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre;
   logic          tick;
   logic          start;
   logic          any_run;
   logic          run_l;
   logic          run_s;
   logic          act_l;
   logic          act_s;
   logic [3:0]    tens_l;
   logic [3:0]    ones_l;
   logic [3:0]    tens_s;
   logic [3:0]    ones_s;

   assign any_run = run_l | run_s;
   assign tick    = any_run && (pre == PRE_LAST);

   // A channel leaving IDLE on this edge; restarts the second so the
   // first one is full length, even across a long/short handoff.
   assign start = (~act_l & en25) | (~act_s & en5 & ~en25);

   always_ff @(posedge clk) begin
      if (!rst)
         pre <= '0;
      else if (start || !any_run || tick)
         pre <= '0;
      else
         pre <= pre + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         err <= 1'b0;
      else if (en25 && en5)
         err <= 1'b1;
   end

   timer_channel #(
      .SEC (LONG_SEC)
   ) u_long (
      .clk     (clk),
      .rst     (rst),
      .en      (en25),
      .tick    (tick),
      .inhibit (1'b0),
      .fin     (fin25),
      .running (run_l),
      .active  (act_l),
      .tens    (tens_l),
      .ones    (ones_l)
   );

   timer_channel #(
      .SEC (SHORT_SEC)
   ) u_short (
      .clk     (clk),
      .rst     (rst),
      .en      (en5),
      .tick    (tick),
      .inhibit (en25),
      .fin     (fin5),
      .running (run_s),
      .active  (act_s),
      .tens    (tens_s),
      .ones    (ones_s)
   );

   assign busy = run_l | run_s;

   // Counts are registered inside the channels, so the display moves on the
   // same edge as the count.
   always_comb begin
      sec_tens = 4'd0;
      sec_ones = 4'd0;
      if (act_l) begin
         sec_tens = tens_l;
         sec_ones = ones_l;
      end else if (act_s) begin
         sec_tens = tens_s;
         sec_ones = ones_s;
      end
   end

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: expected fin pulses are queued when the
// enables are driven and matched against the DUT pulses as they appear.
module tb_phase_timer;

   localparam int TD      = 4;
   localparam int LS      = 12;
   localparam int SS      = 3;
   localparam int LONG_T  = LS * TD;
   localparam int SHORT_T = SS * TD;

   logic       clk  = 1'b0;
   logic       rst  = 1'b0;
   logic       en25 = 1'b0;
   logic       en5  = 1'b0;
   logic       fin25;
   logic       fin5;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       busy;
   logic       err;

   int cyc     = 0;
   int nchecks = 0;
   int nerrors = 0;

   typedef struct {
      int at;
      bit is_long;
   } exp_t;

   exp_t exp_q[$];
   exp_t ev;
   bit   prev_fin = 1'b0;

   phase_timer #(
      .TICK_DIV  (TD),
      .LONG_SEC  (LS),
      .SHORT_SEC (SS),
      .PW        (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en25     (en25),
      .en5      (en5),
      .fin25    (fin25),
      .fin5     (fin5),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r = 8'((v / 10) * 16 + (v % 10));
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nchecks++;
      assert (obs === expv) else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic chk_disp(input string tag, input int v);
      chk(tag, {24'd0, sec_tens, sec_ones}, {24'd0, bcd(v)});
   endtask

   task automatic push(input int at, input bit is_long);
      exp_q.push_back('{at: at, is_long: is_long});
   endtask

   // Pulse scoreboard and pulse-shape rules, sampled 1 time unit after each edge.
   always @(posedge clk) begin
      automatic bit f25;
      automatic bit f5;
      #1;
      f25 = (fin25 === 1'b1);
      f5  = (fin5 === 1'b1);
      nchecks++;
      assert (!(f25 && f5)) else begin
         nerrors++;
         $error("FAIL fin_both: fin25=%0b fin5=%0b expected not both (cycle %0d)", fin25, fin5, cyc);
      end
      nchecks++;
      assert (!(prev_fin && (f25 || f5))) else begin
         nerrors++;
         $error("FAIL fin_adjacent: fin in consecutive cycles, expected isolated pulse (cycle %0d)", cyc);
      end
      if (f25 || f5) begin
         nchecks++;
         assert (exp_q.size() > 0) else begin
            nerrors++;
            $error("FAIL fin_unexpected: fin25=%0b fin5=%0b expected no pulse (cycle %0d)", fin25, fin5, cyc);
         end
         if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            nchecks++;
            assert (cyc == ev.at && {f25, f5} == (ev.is_long ? 2'b10 : 2'b01)) else begin
               nerrors++;
               $error("FAIL fin_match: got fin25=%0b fin5=%0b at cycle %0d, expected %s at cycle %0d",
                      fin25, fin5, cyc, ev.is_long ? "fin25" : "fin5", ev.at);
            end
         end
      end else if (exp_q.size() > 0) begin
         nchecks++;
         assert (exp_q[0].at > cyc) else begin
            nerrors++;
            $error("FAIL fin_missed: no pulse at cycle %0d, expected %s at cycle %0d",
                   cyc, exp_q[0].is_long ? "fin25" : "fin5", exp_q[0].at);
            exp_q.delete(0);
         end
      end
      prev_fin = f25 || f5;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, h, a, b, c, r, r2, e0;

      // Reset
      step(3);
      chk("rst_fin25", fin25, 0);
      chk("rst_fin5", fin5, 0);
      chk_disp("rst_disp", 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst = 1'b1;
      step(2);

      // Long phase countdown
      en25 = 1'b1;
      s = cyc + 1;
      push(s + LONG_T, 1'b1);
      for (int k = 0; k < LS; k++) begin
         wait_to(s + TD * k);
         chk_disp($sformatf("long_disp_%0d", LS - k), LS - k);
      end
      wait_to(s + LONG_T - 1);
      chk_disp("long_last_sec", 1);
      chk("long_busy_before_fin", busy, 1);
      wait_to(s + LONG_T);
      chk_disp("long_expired", 0);
      chk("long_busy_with_fin", busy, 0);

      // Handshake: hold two cycles past fin25, then hand off to short
      wait_to(s + LONG_T + 2);
      chk_disp("long_done_hold", 0);
      en25 = 1'b0;
      en5  = 1'b1;
      h = cyc + 1;
      push(h + SHORT_T, 1'b0);
      wait_to(h);
      chk_disp("short_load", SS);
      chk("short_busy", busy, 1);
      wait_to(h + SHORT_T - 1);
      chk_disp("short_last_sec", 1);
      wait_to(h + SHORT_T);
      chk_disp("short_expired", 0);
      wait_to(h + SHORT_T + 1);
      en5 = 1'b0;
      step(2);

      // Abort in RUN, then restart with a fresh second
      en5 = 1'b1;
      a = cyc + 1;
      push(a + SHORT_T, 1'b0);
      wait_to(a + 5);
      chk_disp("abort_before", 2);
      en5 = 1'b0;
      exp_q.delete(exp_q.size() - 1);
      wait_to(a + 6);
      chk_disp("abort_clear", 0);
      chk("abort_busy", busy, 0);
      wait_to(a + 7);
      en5 = 1'b1;
      b = cyc + 1;
      push(b + SHORT_T, 1'b0);
      wait_to(b + TD - 1);
      chk_disp("restart_full_second", SS);
      wait_to(b + TD);
      chk_disp("restart_first_step", SS - 1);
      wait_to(b + SHORT_T + 1);
      en5 = 1'b0;
      step(2);

      // Conflict: both enables high for one cycle
      chk("err_before_conflict", err, 0);
      en25 = 1'b1;
      en5  = 1'b1;
      c = cyc + 1;
      push(c + LONG_T, 1'b1);
      wait_to(c);
      en5 = 1'b0;
      chk("err_set", err, 1);
      chk_disp("conflict_long_load", LS);
      chk("conflict_busy", busy, 1);
      wait_to(c + TD * 6);
      chk_disp("conflict_long_mid", LS - 6);
      chk("err_sticky_mid", err, 1);
      wait_to(c + LONG_T + 1);
      chk("err_sticky_end", err, 1);
      en25 = 1'b0;
      step(2);

      // Reset mid-run at count 07
      en25 = 1'b1;
      r = cyc + 1;
      push(r + LONG_T, 1'b1);
      wait_to(r + TD * 5);
      chk_disp("pre_reset_count", 7);
      rst = 1'b0;
      exp_q.delete();
      wait_to(r + TD * 5 + 1);
      chk("mrst_fin25", fin25, 0);
      chk("mrst_fin5", fin5, 0);
      chk_disp("mrst_disp", 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_err", err, 0);
      rst = 1'b1;
      r2 = cyc + 1;
      push(r2 + LONG_T, 1'b1);
      wait_to(r2);
      chk_disp("post_reset_load", LS);
      chk("post_reset_busy", busy, 1);
      wait_to(r2 + LONG_T);
      chk_disp("post_reset_expired", 0);
      wait_to(r2 + LONG_T + 1);
      en25 = 1'b0;
      step(2);

      // Controller S0..S3: green/yellow alternation with same-edge handoffs
      for (int st = 0; st < 4; st++) begin
         automatic bit lng;
         automatic int dur;
         lng = (st % 2 == 0);
         dur = lng ? LONG_T : SHORT_T;
         en25 = lng;
         en5  = !lng;
         e0 = cyc + 1;
         push(e0 + dur, lng);
         wait_to(e0);
         chk_disp($sformatf("loop_s%0d_load", st), lng ? LS : SS);
         wait_to(e0 + dur + 1);
      end
      en25 = 1'b0;
      en5  = 1'b0;
      step(3);
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
